code_fetch: RTL and testbench
=============================

# code_fetch

Instruction-byte prefetcher that sits directly upstream of the `cpu` decode/execute loop. On a request for a program counter it streams bytes from a byte-wide, 1-cycle-latency synchronous code memory into an 11-byte window, which is what the opcode plus LEB128 immediate decoder consumes. The window is presented opcode-first in the MSBs with a valid flag and an in-range byte count. An optional reuse path shifts the previous window when the new PC overlaps it, so sequential fetches cost only the missing bytes.

## Interface
- `AW`, 4: code address width in bytes; memory holds 2**AW bytes.
- `WINDOW`, 11: window length in bytes; legal range 2..15.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  start a fetch at `req_pc`; sampled only when `busy`=0.
- `req_pc`  in  AW  address of the opcode byte.
- `flush`  in  1  abort any fill and invalidate the window and cache tag.
- `busy`  out  1  fill in progress.
- `valid`  out  1  `window`/`avail` hold a complete result for the last accepted `req_pc`.
- `window`  out  8*WINDOW  byte at `req_pc` in [8*WINDOW-1 -: 8], next byte below it, and so on.
- `avail`  out  4  count of window bytes whose address is ≤ 2**AW-1.
- `mem_rd`  out  1  memory read strobe.
- `mem_addr`  out  AW  memory read address.
- `mem_data`  in  8  read data, valid the cycle after `mem_rd`.

## Operation
- States: IDLE, FILL (issuing reads), DRAIN (last read data returning), then back to IDLE with `valid`=1.
- Accept: `req`=1 and `busy`=0 and `flush`=0. Accepting clears `valid`, latches `base`=`req_pc`, computes slot list, and sets `busy`.
- Slot i (0..WINDOW-1) has address `base`+i computed in AW+1 bits. If bit AW is set, the slot is out of range: filled with 0x00, no `mem_rd` issued, but it still occupies its issue cycle.
- FILL issues one slot per cycle in ascending order. `mem_rd`=1 with `mem_addr`=slot address for in-range slots. Data is written into its slot one cycle later.
- `avail` = number of in-range slots, valid with `valid`.
- `req` while `busy`=1 is ignored and not queued.
- `flush` has priority over `req` in the same cycle. It forces IDLE, sets `valid`=0, `busy`=0, `mem_rd`=0, invalidates the tag, and discards read data returning the next cycle. `window` contents are don't-care after a flush.
- Reset mid-fill behaves like flush, and also zeroes `window`, `avail` and `mem_addr`.

## Timing
- Reset values: `busy`=0, `valid`=0, `window`=0, `avail`=0, `mem_rd`=0, `mem_addr`=0, tag invalid.
- For a request accepted at edge 0 that needs N slots fetched:
  - `mem_rd` is high (for in-range slots) after edges 1..N.
  - The last data is captured at edge N+1.
  - `valid`=1 and `busy`=0 after edge N+2. Latency is N+2 cycles.
- Full fetch, N=WINDOW: 13 cycles at default.
- `valid` holds until the next accepted `req`, `flush` or reset.

## Configuration
- `CODE_FETCH_REUSE_EN` defined:
  - If the tag is valid and `req_pc` ≥ `base` with k = `req_pc`−`base` < WINDOW, the window shifts left by 8k bits in the accept cycle.
  - Only the last k slots are fetched (N=k).
  - k=0 gives `valid` again after edge 1, with no `mem_rd`.
  - Otherwise a full fetch is done.
- Not defined: every accepted request is a full fetch (N=WINDOW), tag logic is absent, and latency is always WINDOW+2.

## Test plan
- Memory byte[a]=0x10+a, AW=4. Reset released, `req_pc`=0 → `valid` after 13 cycles, `window`=0x10_11_12_13_14_15_16_17_18_19_1A, `avail`=11, eleven `mem_rd` pulses at addresses 0..10.
- With `CODE_FETCH_REUSE_EN`, after the case above, `req_pc`=3 → `valid` after 5 cycles, `window`=0x13…0x1D, `mem_rd` only at 11, 12, 13. Without the macro: 13 cycles, same window.
- `req_pc`=8 → `window`=0x18_19_1A_1B_1C_1D_1E_1F_00_00_00, `avail`=8, no `mem_rd` for the three out-of-range slots, latency 13 cycles.
- `flush` in the 4th FILL cycle, together with `req`=1 → `busy`=0 and `valid`=0 next cycle, request not accepted, late data not written. A following `req_pc`=0 does a full 13-cycle fetch even with reuse enabled.
- `req` pulsed while `busy`=1 with `req_pc`=5 → ignored, and the original fetch completes with its own window.
- `reset` asserted asynchronously mid-fill → all outputs reach their reset values without waiting for a clock edge. After release, `req_pc`=0 yields the first scenario's result.

Source files
------------

// File: rtl/code_fetch_if.sv
// code_fetch_if: request/window and code-memory signals between a fetcher and its host
interface code_fetch_if #(parameter int AW = 4, parameter int WINDOW = 11);
  logic                  req;
  logic [AW-1:0]         req_pc;
  logic                  flush;
  logic                  busy;
  logic                  valid;
  logic [8*WINDOW-1:0]   window;
  logic [3:0]            avail;
  logic                  mem_rd;
  logic [AW-1:0]         mem_addr;
  logic [7:0]            mem_data;
  modport master (output req, req_pc, flush, mem_data, input busy, valid, window, avail, mem_rd, mem_addr);
  modport slave (input req, req_pc, flush, mem_data, output busy, valid, window, avail, mem_rd, mem_addr);
endinterface

// File: rtl/code_fetch.sv
// code_fetch: streams code bytes into an opcode-first window; CODE_FETCH_REUSE_EN enables overlap reuse
module code_fetch #(
  parameter int AW     = 4,
  parameter int WINDOW = 11
) (
  input logic        clk,
  input logic        reset,
  code_fetch_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [3:0] LAST  = 4'(WINDOW - 1);
  logic [1:0]          r_state;
  logic [AW-1:0]       r_base;
  logic [3:0]          r_idx;
  logic                r_valid;
  logic [8*WINDOW-1:0] r_window;
  logic [3:0]          r_avail;
  logic                r_mem_rd;
  logic [AW-1:0]       r_mem_addr;
  logic                r_p1_v, r_p1_inr, r_p2_v, r_p2_inr;
  logic [3:0]          r_p1_slot, r_p2_slot;
  logic                w_acc, w_none;
  logic [3:0]          w_start, w_avail;
  logic [AW:0]         w_addr, w_room;
`ifdef CODE_FETCH_REUSE_EN
  logic                r_tag;
  logic                w_hit;
  logic [AW-1:0]       w_k;
`endif
  // accept decode, current slot address, in-range count and reuse offset
  always_comb begin
    w_acc   = bus.req && r_state == IDLE && !bus.flush;
    w_addr  = {1'b0, r_base} + (AW+1)'(r_idx);
    w_room  = (AW+1)'(2**AW) - {1'b0, bus.req_pc};
    w_avail = w_room > (AW+1)'(WINDOW) ? 4'(WINDOW) : 4'(w_room);
`ifdef CODE_FETCH_REUSE_EN
    w_k     = bus.req_pc - r_base;
    w_hit   = r_tag && bus.req_pc >= r_base && 8'(w_k) < 8'(WINDOW);
    w_start = w_hit ? LAST + 4'd1 - 4'(w_k) : 4'd0;
    w_none  = w_hit && w_k == '0;
`else
    w_start = 4'd0;
    w_none  = 1'b0;
`endif
  end
  // fetch sequencer: issue one slot per cycle, land data two edges later, then flag valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_window   <= '0;
      r_avail    <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_p1_v     <= 1'b0;
      r_p1_inr   <= 1'b0;
      r_p1_slot  <= '0;
      r_p2_v     <= 1'b0;
      r_p2_inr   <= 1'b0;
      r_p2_slot  <= '0;
`ifdef CODE_FETCH_REUSE_EN
      r_tag      <= 1'b0;
`endif
    end else if (bus.flush) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_mem_rd <= 1'b0;
      r_p1_v   <= 1'b0;
      r_p2_v   <= 1'b0;
`ifdef CODE_FETCH_REUSE_EN
      r_tag    <= 1'b0;
`endif
    end else begin
      r_mem_rd  <= 1'b0;
      r_p1_v    <= 1'b0;
      r_p2_v    <= r_p1_v;
      r_p2_inr  <= r_p1_inr;
      r_p2_slot <= r_p1_slot;
      if (r_p2_v)
        r_window[8*(WINDOW-int'(r_p2_slot))-1 -: 8] <= r_p2_inr ? bus.mem_data : 8'h00;
      if (w_acc) begin
        r_valid <= 1'b0;
        r_base  <= bus.req_pc;
        r_avail <= w_avail;
        r_idx   <= w_start;
        r_state <= w_none ? DRAIN : FILL;
`ifdef CODE_FETCH_REUSE_EN
        if (w_hit)
          r_window <= r_window << {w_k, 3'b000};
`endif
      end else if (r_state == FILL) begin
        r_mem_rd   <= !w_addr[AW];
        r_mem_addr <= w_addr[AW-1:0];
        r_p1_v     <= 1'b1;
        r_p1_inr   <= !w_addr[AW];
        r_p1_slot  <= r_idx;
        r_idx      <= r_idx + 4'd1;
        if (r_idx == LAST)
          r_state <= DRAIN;
      end else if (r_state == DRAIN && !r_p1_v) begin
        r_state <= IDLE;
        r_valid <= 1'b1;
`ifdef CODE_FETCH_REUSE_EN
        r_tag   <= 1'b1;
`endif
      end
    end
  end
  assign bus.busy     = r_state != IDLE;
  assign bus.valid    = r_valid;
  assign bus.window   = r_window;
  assign bus.avail    = r_avail;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
endmodule

// File: tb/tb_code_fetch.sv
// tb_code_fetch: directed checks of code_fetch against a byte[a]=0x10+a code memory
module tb_code_fetch;
`ifdef CODE_FETCH_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam logic [87:0] W0 = 88'h101112131415161718191A;
  localparam logic [87:0] W2 = 88'h12131415161718191A1B1C;
  localparam logic [87:0] W3 = 88'h131415161718191A1B1C1D;
  localparam logic [87:0] W8 = 88'h18191A1B1C1D1E1F000000;
  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt;
  logic [15:0] rd_mask;
  code_fetch_if #(.AW(4), .WINDOW(11)) bus ();
  code_fetch #(.AW(4), .WINDOW(11)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // one-cycle-latency code memory
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= 8'h10 + {4'h0, bus.mem_addr};
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    if (bus.mem_rd) begin
      rd_cnt++;
      rd_mask[bus.mem_addr] = 1'b1;
    end
  endtask
  task automatic start(input logic [3:0] pc);
    rd_cnt  = 0;
    rd_mask = '0;
    @(negedge clk);
    bus.req    = 1'b1;
    bus.req_pc = pc;
    tick();
    bus.req = 1'b0;
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask
  task automatic fetch(input string tag, input logic [3:0] pc, output int cyc);
    start(pc);
    check({tag, "_busy_hi"}, bus.busy, 1'b1);
    wait_valid(cyc);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_valid"}, bus.valid, 1'b0);
    check({tag, "_window"}, bus.window, '0);
    check({tag, "_avail"}, bus.avail, 4'd0);
    check({tag, "_mem_rd"}, bus.mem_rd, 1'b0);
    check({tag, "_mem_addr"}, bus.mem_addr, 4'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int c;
    reset      = 1'b0;
    bus.req    = 1'b0;
    bus.req_pc = '0;
    bus.flush  = 1'b0;
    #3;
    check_reset("rst");
    #20 reset = 1'b1;
    fetch("pc0", 4'd0, c);
    check("pc0_latency", c, 13);
    check("pc0_window", bus.window, W0);
    check("pc0_avail", bus.avail, 4'd11);
    check("pc0_rd_cnt", rd_cnt, 11);
    check("pc0_rd_mask", rd_mask, 16'h07FF);
    check("pc0_busy", bus.busy, 1'b0);
    fetch("pc3", 4'd3, c);
    check("pc3_latency", c, REUSE ? 5 : 13);
    check("pc3_window", bus.window, W3);
    check("pc3_avail", bus.avail, 4'd11);
    check("pc3_rd_cnt", rd_cnt, REUSE ? 3 : 11);
    check("pc3_rd_mask", rd_mask, REUSE ? 16'h3800 : 16'h3FF8);
    @(negedge clk);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", bus.valid, 1'b0);
    fetch("pc8", 4'd8, c);
    check("pc8_latency", c, 13);
    check("pc8_window", bus.window, W8);
    check("pc8_avail", bus.avail, 4'd8);
    check("pc8_rd_cnt", rd_cnt, 8);
    check("pc8_rd_mask", rd_mask, 16'hFF00);
    start(4'd0);
    tick();
    tick();
    tick();
    @(negedge clk);
    bus.flush  = 1'b1;
    bus.req    = 1'b1;
    bus.req_pc = 4'd5;
    tick();
    bus.flush = 1'b0;
    bus.req   = 1'b0;
    check("mid_flush_busy", bus.busy, 1'b0);
    check("mid_flush_valid", bus.valid, 1'b0);
    check("mid_flush_mem_rd", bus.mem_rd, 1'b0);
    tick();
    tick();
    tick();
    check("mid_flush_no_accept_busy", bus.busy, 1'b0);
    check("mid_flush_no_accept_valid", bus.valid, 1'b0);
    fetch("post_flush", 4'd0, c);
    check("post_flush_latency", c, 13);
    check("post_flush_window", bus.window, W0);
    check("post_flush_rd_cnt", rd_cnt, 11);
    start(4'd2);
    tick();
    @(negedge clk);
    bus.req    = 1'b1;
    bus.req_pc = 4'd5;
    tick();
    bus.req = 1'b0;
    wait_valid(c);
    c += 2;
    check("busy_req_latency", c, REUSE ? 4 : 13);
    check("busy_req_window", bus.window, W2);
    check("busy_req_avail", bus.avail, 4'd11);
    tick();
    tick();
    tick();
    check("busy_req_hold_valid", bus.valid, 1'b1);
    check("busy_req_not_queued", bus.busy, 1'b0);
    check("busy_req_hold_window", bus.window, W2);
    start(4'd0);
    tick();
    tick();
    tick();
    #3 reset = 1'b0;
    #1;
    check_reset("arst");
    #2 reset = 1'b1;
    fetch("after_rst", 4'd0, c);
    check("after_rst_latency", c, 13);
    check("after_rst_window", bus.window, W0);
    check("after_rst_avail", bus.avail, 4'd11);
    check("after_rst_rd_cnt", rd_cnt, 11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
